// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, valid/ready on both sides.
// Optional leading-zero blanking with code 4'd11 when BIN2BCD_SEQ_LEADING_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   sr_reg;
  logic [BCD_W-1:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_reg;
  logic [BCD_W-1:0]   out_bcd_reg;
  logic               out_ovf_reg;

  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_shift;
  logic               unused_top;
  logic [BCD_W-1:0]   digits_shown;
  logic [BCD_W-1:0]   result_bcd;
  logic               last_shift;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid && in_ready) state_next = SHIFT;
      SHIFT:   if (last_shift)           state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = (state_reg == DONE);
  end

  assign last_shift = (cnt_reg == CNT_W'(1));

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign acc_adj[4*gi +: 4] = (acc_reg[4*gi +: 4] >= 4'd5) ? acc_reg[4*gi +: 4] + 4'd3
                                                                : acc_reg[4*gi +: 4];
    end
  endgenerate

  // The bit leaving the top digit is dropped; it only matters on overflow, which is masked anyway.
  assign {unused_top, acc_shift} = {acc_adj, sr_reg[WIDTH-1]};

`ifdef BIN2BCD_SEQ_LEADING_BLANK_EN
  always_comb begin
    logic seen_nonzero;
    digits_shown = acc_shift;
    seen_nonzero = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (acc_shift[4*i +: 4] != 4'd0) seen_nonzero = 1'b1;
      if (!seen_nonzero) digits_shown[4*i +: 4] = 4'd11;
    end
  end
`else
  assign digits_shown = acc_shift;
`endif

  assign result_bcd = ovf_reg ? {DIGITS{4'd11}} : digits_shown;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg      <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ovf_reg     <= 1'b0;
      out_bcd_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            sr_reg  <= in_bin;
            acc_reg <= '0;
            cnt_reg <= CNT_W'(WIDTH);
            ovf_reg <= (64'(in_bin) >= LIMIT);
          end
        end
        SHIFT: begin
          sr_reg  <= sr_reg << 1;
          acc_reg <= acc_shift;
          cnt_reg <= cnt_reg - CNT_W'(1);
          // Result registers load on the final shift so they are valid on entry to DONE.
          if (last_shift) begin
            out_bcd_reg <= result_bcd;
            out_ovf_reg <= ovf_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_bcd = out_bcd_reg;
  assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: two instances (7-bit/2-digit and 10-bit/3-digit),
// a vector table, hand-written backpressure/reset sequences and randomized conversions.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_ovf_a;
  logic [6:0]  in_bin_a;
  logic [7:0]  out_bcd_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_ovf_b;
  logic [9:0]  in_bin_b;
  logic [11:0] out_bcd_b;

  bin2bcd_seq #(.WIDTH(7), .DIGITS(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_bin(in_bin_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_bcd(out_bcd_a), .out_ovf(out_ovf_a));

  bin2bcd_seq #(.WIDTH(10), .DIGITS(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_bin(in_bin_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_bcd(out_bcd_b), .out_ovf(out_ovf_b));

  int total = 0;
  int passed = 0;

  typedef struct {
    bit          sel;
    int unsigned val;
    logic [11:0] bcd_plain;
    logic [11:0] bcd_blank;
    bit          ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic longint unsigned p10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic bit model_ovf(input longint unsigned v, input int d);
    return v >= p10(d);
  endfunction

  // Decimal digits by plain division; overflow and optional blanking from the display rules.
  function automatic logic [11:0] model_bcd(input longint unsigned v, input int d);
    logic [11:0] r;
    r = '0;
    if (model_ovf(v, d)) begin
      for (int i = 0; i < d; i++) r[4*i +: 4] = 4'd11;
      return r;
    end
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
`ifdef BIN2BCD_SEQ_LEADING_BLANK_EN
    for (int i = d - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'd11;
    end
`endif
    return r;
  endfunction

  function automatic logic sel_ready(input bit sel);
    return sel ? in_ready_b : in_ready_a;
  endfunction

  function automatic logic sel_valid(input bit sel);
    return sel ? out_valid_b : out_valid_a;
  endfunction

  function automatic logic [11:0] sel_bcd(input bit sel);
    return sel ? out_bcd_b : {4'h0, out_bcd_a};
  endfunction

  function automatic logic sel_ovf(input bit sel);
    return sel ? out_ovf_b : out_ovf_a;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One conversion; stall = cycles the consumer holds out_ready low once the result is up.
  task automatic convert(input bit sel, input int unsigned v, input int stall,
                         output logic [11:0] bcd, output bit ovf, output int lat);
    int n;
    n = 0;
    while (!sel_ready(sel) && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      total++;
      $display("FAIL in_ready timeout: got 0, expected 1 within 50 cycles");
    end
    if (sel) begin
      in_bin_b = 10'(v); in_valid_b = 1'b1; out_ready_b = (stall == 0);
    end else begin
      in_bin_a = 7'(v);  in_valid_a = 1'b1; out_ready_a = (stall == 0);
    end
    tick();
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 1;
    while (!sel_valid(sel) && lat < 60) begin tick(); lat++; end
    if (lat >= 60) begin
      total++;
      $display("FAIL out_valid timeout: got 0, expected 1 within 60 cycles");
    end
    bcd = sel_bcd(sel);
    ovf = sel_ovf(sel);
    if (stall > 0) begin
      repeat (stall) tick();
      check("stall_hold_valid", sel_valid(sel), 1);
      check("stall_hold_bcd", sel_bcd(sel), bcd);
    end
    out_ready_a = 1'b1;
    out_ready_b = 1'b1;
    tick();
  endtask

  initial begin
    logic [11:0] bcd, exp_bcd;
    bit ovf;
    int lat, n, seen;

    vecs[0]  = '{0, 42,   12'h042, 12'h042, 0};
    vecs[1]  = '{0, 99,   12'h099, 12'h099, 0};
    vecs[2]  = '{0, 0,    12'h000, 12'h0B0, 0};
    vecs[3]  = '{0, 100,  12'h0BB, 12'h0BB, 1};
    vecs[4]  = '{0, 127,  12'h0BB, 12'h0BB, 1};
    vecs[5]  = '{0, 5,    12'h005, 12'h0B5, 0};
    vecs[6]  = '{0, 7,    12'h007, 12'h0B7, 0};
    vecs[7]  = '{0, 40,   12'h040, 12'h040, 0};
    vecs[8]  = '{1, 999,  12'h999, 12'h999, 0};
    vecs[9]  = '{1, 1000, 12'hBBB, 12'hBBB, 1};
    vecs[10] = '{1, 1023, 12'hBBB, 12'hBBB, 1};
    vecs[11] = '{1, 5,    12'h005, 12'hBB5, 0};
    vecs[12] = '{1, 50,   12'h050, 12'hB50, 0};

    rst = 1'b1;
    in_valid_a = 1'b0; in_bin_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_bin_b = '0; out_ready_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_in_ready_a", in_ready_a, 1);
    check("reset_out_valid_a", out_valid_a, 0);
    check("reset_out_bcd_a", out_bcd_a, 0);
    check("reset_out_ovf_a", out_ovf_a, 0);
    check("reset_in_ready_b", in_ready_b, 1);
    check("reset_out_valid_b", out_valid_b, 0);
    check("reset_out_bcd_b", out_bcd_b, 0);

    for (int i = 0; i < 13; i++) begin
`ifdef BIN2BCD_SEQ_LEADING_BLANK_EN
      exp_bcd = vecs[i].bcd_blank;
`else
      exp_bcd = vecs[i].bcd_plain;
`endif
      convert(vecs[i].sel, vecs[i].val, 0, bcd, ovf, lat);
      $display("vec %0d: in=%0d bcd=%h ovf=%0d latency=%0d", i, vecs[i].val, bcd, ovf, lat);
      check($sformatf("vec%0d_bcd", i), bcd, exp_bcd);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].sel ? 11 : 8);
    end

    // Backpressure: 37 held in DONE for 6 cycles, a stray in_valid pulse must be dropped.
    out_ready_a = 1'b0;
    in_bin_a = 7'd37; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    n = 0;
    while (!out_valid_a && n < 40) begin tick(); n++; end
    check("bp_reach_done", out_valid_a, 1);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("bp%0d_valid", k), out_valid_a, 1);
      check($sformatf("bp%0d_bcd", k), out_bcd_a, model_bcd(37, 2));
      check($sformatf("bp%0d_in_ready", k), in_ready_a, 0);
      in_valid_a = (k == 2);
      in_bin_a = 7'd12;
      tick();
      in_valid_a = 1'b0;
    end
    out_ready_a = 1'b1;
    tick();
    $display("backpressure: released, in_ready=%0d out_valid=%0d", in_ready_a, out_valid_a);
    check("bp_release_in_ready", in_ready_a, 1);
    check("bp_release_valid", out_valid_a, 0);
    seen = 0;
    repeat (12) begin tick(); if (out_valid_a) seen++; end
    check("bp_pulse_ignored", seen, 0);

    // Reset three cycles into a conversion of 88.
    in_bin_a = 7'd88; in_valid_a = 1'b1;
    tick();
    in_valid_a = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset mid-shift: in_ready=%0d out_valid=%0d bcd=%h ovf=%0d",
             in_ready_a, out_valid_a, out_bcd_a, out_ovf_a);
    check("rst_mid_in_ready", in_ready_a, 1);
    check("rst_mid_valid", out_valid_a, 0);
    check("rst_mid_bcd", out_bcd_a, 0);
    check("rst_mid_ovf", out_ovf_a, 0);
    seen = 0;
    repeat (12) begin tick(); if (out_valid_a) seen++; end
    check("rst_mid_no_valid", seen, 0);
    convert(0, 64, 0, bcd, ovf, lat);
    $display("after reset: in=64 bcd=%h ovf=%0d", bcd, ovf);
    check("rst_after_bcd", bcd, model_bcd(64, 2));
    check("rst_after_ovf", ovf, 0);

    for (int i = 0; i < 40; i++) begin
      bit sel;
      int unsigned v;
      int stall;
      sel = 1'($urandom_range(0, 1));
      v = sel ? $urandom_range(0, 1023) : $urandom_range(0, 127);
      stall = $urandom_range(0, 3);
      convert(sel, v, stall, bcd, ovf, lat);
      $display("rand %0d: dut=%0d in=%0d stall=%0d bcd=%h ovf=%0d", i, sel, v, stall, bcd, ovf);
      check($sformatf("rand%0d_bcd", i), bcd, model_bcd(v, sel ? 3 : 2));
      check($sformatf("rand%0d_ovf", i), ovf, model_ovf(v, sel ? 3 : 2));
      check($sformatf("rand%0d_latency", i), lat, sel ? 11 : 8);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
